dm_sba_master: RTL and testbench

- System Bus Access (SBA) engine of the RISC-V debug module.
- Turns sbaddress/sbdata requests from the debug CSR block into single transactions on a simple req/gnt/r_valid bus master port.
- Returns read data and completion to the CSR block and reports busy and access-size errors.
- Sits between the DM CSR file and the SoC interconnect master port.

---
 rtl/dm_sba_master.sv | 133 +++++++++++++
 tb/tb_dm_sba_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_master.sv
// System bus access engine: turns debugger sbaddress/sbdata requests into single
// req/gnt/r_valid bus transactions, returning read data and reporting size errors.
module dm_sba_master #(
  parameter int unsigned BusWidth       = 32,
  parameter bit          ReadByteEnable = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,

  output logic                  master_req_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,

  input  logic [BusWidth-1:0]   sbaddress_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadondata_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o
);

  localparam int unsigned BeW       = BusWidth / 8;
  localparam int unsigned IdxW      = $clog2(BeW);
  localparam logic [2:0]  MaxAccess = 3'(IdxW);

  typedef enum logic [2:0] {Idle, Read, Write, WaitRead, WaitWrite} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx, idx_h, idx_w;
  logic [BeW-1:0]       be_mask;
  logic [BusWidth-1:0]  addr_inc;
  logic                 size_err;
  logic                 unused_dmactive;

  assign unused_dmactive = dmactive_i;

  assign master_add_o   = sbaddress_i;
  assign master_wdata_o = sbdata_i;
  assign sbdata_o       = master_r_rdata_i;
  assign sbdata_valid_o = master_r_valid_i;
  assign sbbusy_o       = (state_q != Idle);

  assign size_err = (state_q != Idle) && (sbaccess_i > MaxAccess);
  assign addr_inc = sbautoincrement_i ? (BusWidth'(1) << sbaccess_i) : '0;

  // Lanes are aligned down to the access size; misalignment is silently tolerated.
  always_comb begin
    idx      = sbaddress_i[IdxW-1:0];
    idx_h    = idx;
    idx_h[0] = 1'b0;
    idx_w    = idx;
    idx_w[1:0] = 2'b00;
    be_mask  = '0;
    case (sbaccess_i)
      3'd0:    be_mask = BeW'(1) << idx;
      3'd1:    be_mask = BeW'(3) << idx_h;
      3'd2:    be_mask = (BusWidth == 32) ? '1 : (BeW'(15) << idx_w);
      3'd3:    be_mask = '1;
      default: be_mask = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Idle triggers are checked in sequence so a read-on-data request wins over a write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle: begin
        if (sbaddress_write_valid_i && sbreadonaddr_i) state_d = Read;
        if (sbdata_write_valid_i)                      state_d = Write;
        if (sbdata_read_valid_i && sbreadondata_i)     state_d = Read;
      end
      Read:      if (master_gnt_i)     state_d = WaitRead;
      Write:     if (master_gnt_i)     state_d = WaitWrite;
      WaitRead:  if (master_r_valid_i) state_d = Idle;
      WaitWrite: if (master_r_valid_i) state_d = Idle;
      default:   state_d = Idle;
    endcase
    if (size_err) state_d = Idle;
  end

  always_comb begin
    master_req_o    = 1'b0;
    master_we_o     = 1'b0;
    master_be_o     = '0;
    sbaddress_o     = sbaddress_i;
    sberror_valid_o = 1'b0;
    sberror_o       = 3'd0;
    case (state_q)
      Read: begin
        master_req_o = 1'b1;
        master_be_o  = ReadByteEnable ? be_mask : '0;
      end
      Write: begin
        master_req_o = 1'b1;
        master_we_o  = 1'b1;
        master_be_o  = be_mask;
      end
      WaitRead, WaitWrite: begin
        if (master_r_valid_i) sbaddress_o = sbaddress_i + addr_inc;
      end
      default: ;
    endcase
    if (size_err) begin
      master_req_o    = 1'b0;
      sberror_valid_o = 1'b1;
      sberror_o       = 3'd4;
    end
  end

endmodule

// File: tb/tb_dm_sba_master.sv
// Bench for dm_sba_master: directed sequences, a trigger/byte-enable table and a
// randomized run against a transaction-level reference model.
module tb_dm_sba_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dmactive_i = 1'b1;
  logic        master_gnt_i = 1'b0, master_r_valid_i = 1'b0;
  logic [31:0] master_r_rdata_i = '0;
  logic [31:0] sbaddress_i = '0, sbdata_i = '0;
  logic        sbaddress_write_valid_i = 1'b0, sbreadonaddr_i = 1'b0, sbautoincrement_i = 1'b0;
  logic [2:0]  sbaccess_i = 3'd2;
  logic        sbreadondata_i = 1'b0, sbdata_read_valid_i = 1'b0, sbdata_write_valid_i = 1'b0;

  logic        master_req_o, master_we_o, sbdata_valid_o, sbbusy_o, sberror_valid_o;
  logic [31:0] master_add_o, master_wdata_o, sbaddress_o, sbdata_o;
  logic [3:0]  master_be_o;
  logic [2:0]  sberror_o;

  logic        b_req, b_we, b_sbdv, b_busy, b_errv;
  logic [31:0] b_add, b_wdata, b_sbaddr, b_sbdata;
  logic [3:0]  b_be;
  logic [2:0]  b_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  dm_sba_master #(.BusWidth(32), .ReadByteEnable(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
    .master_req_o(master_req_o), .master_add_o(master_add_o), .master_we_o(master_we_o),
    .master_wdata_o(master_wdata_o), .master_be_o(master_be_o), .master_gnt_i(master_gnt_i),
    .master_r_valid_i(master_r_valid_i), .master_r_rdata_i(master_r_rdata_i),
    .sbaddress_i(sbaddress_i), .sbaddress_o(sbaddress_o),
    .sbaddress_write_valid_i(sbaddress_write_valid_i), .sbreadonaddr_i(sbreadonaddr_i),
    .sbautoincrement_i(sbautoincrement_i), .sbaccess_i(sbaccess_i),
    .sbreadondata_i(sbreadondata_i), .sbdata_i(sbdata_i),
    .sbdata_read_valid_i(sbdata_read_valid_i), .sbdata_write_valid_i(sbdata_write_valid_i),
    .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o), .sbbusy_o(sbbusy_o),
    .sberror_valid_o(sberror_valid_o), .sberror_o(sberror_o)
  );

  dm_sba_master #(.BusWidth(32), .ReadByteEnable(1'b0)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
    .master_req_o(b_req), .master_add_o(b_add), .master_we_o(b_we),
    .master_wdata_o(b_wdata), .master_be_o(b_be), .master_gnt_i(master_gnt_i),
    .master_r_valid_i(master_r_valid_i), .master_r_rdata_i(master_r_rdata_i),
    .sbaddress_i(sbaddress_i), .sbaddress_o(b_sbaddr),
    .sbaddress_write_valid_i(sbaddress_write_valid_i), .sbreadonaddr_i(sbreadonaddr_i),
    .sbautoincrement_i(sbautoincrement_i), .sbaccess_i(sbaccess_i),
    .sbreadondata_i(sbreadondata_i), .sbdata_i(sbdata_i),
    .sbdata_read_valid_i(sbdata_read_valid_i), .sbdata_write_valid_i(sbdata_write_valid_i),
    .sbdata_o(b_sbdata), .sbdata_valid_o(b_sbdv), .sbbusy_o(b_busy),
    .sberror_valid_o(b_errv), .sberror_o(b_err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic clear_inputs();
    sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0; sbdata_write_valid_i = 1'b0;
    sbdata_read_valid_i = 1'b0; sbreadondata_i = 1'b0; sbautoincrement_i = 1'b0;
    master_gnt_i = 1'b0; master_r_valid_i = 1'b0;
  endtask

  // Called one time unit after the negedge while a request is outstanding.
  task automatic complete_txn(input string nm);
    @(negedge clk_i); master_gnt_i = 1'b1;
    @(negedge clk_i); master_gnt_i = 1'b0; master_r_valid_i = 1'b1;
    @(negedge clk_i); master_r_valid_i = 1'b0;
    #1 chk(nm, sbbusy_o, 1'b0);
  endtask

  // Byte mask from the access size: lanes of the access, aligned down within the word.
  function automatic logic [3:0] mask_ref(input int acc, input logic [31:0] a);
    int sz;
    int off;
    if (acc == 2 || acc == 3) return 4'hF;
    if (acc > 3) return 4'h0;
    sz  = 1 << acc;
    off = (int'(a % 4) / sz) * sz;
    return 4'(((1 << sz) - 1) << off);
  endfunction

  typedef struct {
    logic [4:0]  trig;   // {addr_wv, readonaddr, data_wv, data_rv, readondata}
    logic [2:0]  acc;
    logic [31:0] addr;
    logic        busy;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  be_b;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          m_act, m_wr, m_gnt;
    bit          e_err, e_req, e_we;
    logic [3:0]  mk, e_be, e_be_b;
    logic [31:0] e_addr;
    int          acc;

    tbl[0] = '{5'b11000, 3'd0, 32'h0000_0102, 1'b1, 1'b0, 4'h4, 4'h0};
    tbl[1] = '{5'b10000, 3'd2, 32'h0000_0000, 1'b0, 1'b0, 4'h0, 4'h0};
    tbl[2] = '{5'b11100, 3'd0, 32'h0000_0003, 1'b1, 1'b1, 4'h8, 4'h8};
    tbl[3] = '{5'b00111, 3'd1, 32'h0000_0001, 1'b1, 1'b0, 4'h3, 4'h0};
    tbl[4] = '{5'b00010, 3'd2, 32'h0000_0000, 1'b0, 1'b0, 4'h0, 4'h0};
    tbl[5] = '{5'b00011, 3'd1, 32'h0000_0003, 1'b1, 1'b0, 4'hC, 4'h0};
    tbl[6] = '{5'b00100, 3'd1, 32'h0000_0002, 1'b1, 1'b1, 4'hC, 4'hC};
    tbl[7] = '{5'b00100, 3'd2, 32'h0000_0005, 1'b1, 1'b1, 4'hF, 4'hF};
    tbl[8] = '{5'b00100, 3'd0, 32'h0000_0000, 1'b1, 1'b1, 4'h1, 4'h1};
    tbl[9] = '{5'b11111, 3'd0, 32'h0000_0001, 1'b1, 1'b0, 4'h2, 4'h0};

    // Reset state
    @(negedge clk_i); @(negedge clk_i);
    #1 chk("rst_outputs", {sbbusy_o, master_req_o, master_we_o, master_be_o, sberror_valid_o, sberror_o},
           {1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0});
    @(negedge clk_i); rst_ni = 1'b1;

    // Word read with response
    @(negedge clk_i); sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1; sbaddress_i = 32'h1000;
    sbaddress_write_valid_i = 1'b1;
    #1 chk("rd_idle_req", master_req_o, 1'b0);
    @(negedge clk_i); sbaddress_write_valid_i = 1'b0;
    #1 chk("rd_req", {master_req_o, master_we_o, master_add_o, master_be_o, sbbusy_o},
           {1'b1, 1'b0, 32'h1000, 4'hF, 1'b1});
    @(negedge clk_i); master_gnt_i = 1'b1;
    #1 chk("rd_req_at_gnt", master_req_o, 1'b1);
    @(negedge clk_i); master_gnt_i = 1'b0;
    #1 chk("rd_wait", {master_req_o, sbbusy_o}, {1'b0, 1'b1});
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEADBEEF;
    #1 chk("rd_data", {sbdata_valid_o, sbdata_o, sbaddress_o}, {1'b1, 32'hDEADBEEF, 32'h1000});
    @(negedge clk_i); master_r_valid_i = 1'b0;
    #1 chk("rd_done", sbbusy_o, 1'b0);
    clear_inputs();

    // Byte write with grant held off
    @(negedge clk_i); sbaccess_i = 3'd0; sbaddress_i = 32'h1003; sbdata_i = 32'hAB;
    sbdata_write_valid_i = 1'b1;
    @(negedge clk_i); sbdata_write_valid_i = 1'b0;
    #1 chk("wr_req", {master_req_o, master_we_o, master_be_o, master_wdata_o},
           {1'b1, 1'b1, 4'b1000, 32'hAB});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1 chk("wr_req_held", master_req_o, 1'b1);
    end
    complete_txn("wr_done");

    // Auto-increment of a halfword read
    @(negedge clk_i); sbautoincrement_i = 1'b1; sbaccess_i = 3'd1; sbaddress_i = 32'h2000;
    sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1;
    @(negedge clk_i); sbaddress_write_valid_i = 1'b0;
    #1 chk("inc_read_state", sbaddress_o, 32'h2000);
    @(negedge clk_i); master_gnt_i = 1'b1;
    @(negedge clk_i); master_gnt_i = 1'b0;
    #1 chk("inc_wait_no_rvalid", sbaddress_o, 32'h2000);
    master_r_valid_i = 1'b1;
    #1 chk("inc_rvalid", sbaddress_o, 32'h2002);
    @(negedge clk_i); master_r_valid_i = 1'b0;
    #1 chk("inc_after", {sbbusy_o, sbaddress_o}, {1'b0, 32'h2000});
    clear_inputs();

    // Oversized access
    @(negedge clk_i); sbaccess_i = 3'd3; sbaddress_i = 32'h4000; sbdata_write_valid_i = 1'b1;
    @(negedge clk_i); sbdata_write_valid_i = 1'b0;
    #1 chk("err_pulse", {sberror_valid_o, sberror_o, master_req_o}, {1'b1, 3'd4, 1'b0});
    @(negedge clk_i);
    #1 chk("err_back_idle", {sbbusy_o, sberror_valid_o, sberror_o}, {1'b0, 1'b0, 3'd0});

    // Read byte enables suppressed on the second instance
    @(negedge clk_i); sbaccess_i = 3'd1; sbaddress_i = 32'h1002; sbreadonaddr_i = 1'b1;
    sbaddress_write_valid_i = 1'b1;
    @(negedge clk_i); sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
    #1 chk("rbe0_read_be", {b_be, master_be_o}, {4'h0, 4'b1100});
    complete_txn("rbe0_read_done");
    @(negedge clk_i); sbdata_write_valid_i = 1'b1;
    @(negedge clk_i); sbdata_write_valid_i = 1'b0;
    #1 chk("rbe0_write_be", b_be, 4'b1100);
    complete_txn("rbe0_write_done");

    // Asynchronous reset during WaitRead
    @(negedge clk_i); sbaccess_i = 3'd2; sbaddress_i = 32'h3000; sbreadonaddr_i = 1'b1;
    sbaddress_write_valid_i = 1'b1;
    @(negedge clk_i); sbaddress_write_valid_i = 1'b0; master_gnt_i = 1'b1;
    @(negedge clk_i); master_gnt_i = 1'b0;
    #1 chk("rst_mid_busy", sbbusy_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1 chk("rst_mid_drop", {sbbusy_o, master_req_o, b_busy}, {1'b0, 1'b0, 1'b0});
    @(negedge clk_i); rst_ni = 1'b1; sbreadonaddr_i = 1'b0; master_r_valid_i = 1'b1;
    @(negedge clk_i); master_r_valid_i = 1'b0;
    #1 chk("rst_stray_rvalid", {sbbusy_o, master_req_o}, {1'b0, 1'b0});

    // Trigger priority and byte-enable table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      {sbaddress_write_valid_i, sbreadonaddr_i, sbdata_write_valid_i,
       sbdata_read_valid_i, sbreadondata_i} = tbl[i].trig;
      sbaccess_i = tbl[i].acc; sbaddress_i = tbl[i].addr;
      @(negedge clk_i); clear_inputs();
      #1 chk($sformatf("tbl%0d", i), {sbbusy_o, master_we_o, master_be_o, b_be},
             {tbl[i].busy, tbl[i].we, tbl[i].be, tbl[i].be_b});
      if (tbl[i].busy) complete_txn($sformatf("tbl%0d_done", i));
    end

    // Randomized run against the transaction-level model
    m_act = 1'b0; m_wr = 1'b0; m_gnt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      sbaddress_i = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      sbaccess_i  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      sbaddress_write_valid_i = ($urandom_range(0, 5) == 0);
      sbreadonaddr_i          = $urandom_range(0, 1) == 1;
      sbdata_write_valid_i    = ($urandom_range(0, 7) == 0);
      sbdata_read_valid_i     = ($urandom_range(0, 5) == 0);
      sbreadondata_i          = $urandom_range(0, 1) == 1;
      sbautoincrement_i       = $urandom_range(0, 1) == 1;
      master_gnt_i            = $urandom_range(0, 1) == 1;
      master_r_valid_i        = ($urandom_range(0, 2) == 0);
      sbdata_i = $urandom; master_r_rdata_i = $urandom;
      #1;
      acc    = int'(sbaccess_i);
      mk     = mask_ref(acc, sbaddress_i);
      e_err  = m_act && (acc > 2);
      e_req  = m_act && !m_gnt && !e_err;
      e_we   = m_act && !m_gnt && m_wr;
      e_be   = (m_act && !m_gnt) ? mk : 4'h0;
      e_be_b = (m_act && !m_gnt && m_wr) ? mk : 4'h0;
      e_addr = sbaddress_i +
               ((m_act && m_gnt && master_r_valid_i && sbautoincrement_i) ? (32'd1 << acc) : 32'd0);
      chk("rnd_ctrl", {master_req_o, master_we_o, master_be_o, sbbusy_o, sberror_valid_o, sberror_o},
          {e_req, e_we, e_be, m_act, e_err, e_err ? 3'd4 : 3'd0});
      chk("rnd_sbaddr", sbaddress_o, e_addr);
      chk("rnd_pass", {master_add_o, master_wdata_o, sbdata_o, sbdata_valid_o},
          {sbaddress_i, sbdata_i, master_r_rdata_i, master_r_valid_i});
      chk("rnd_b", {b_req, b_we, b_be, b_busy, b_errv, b_err, b_sbaddr, b_add, b_wdata, b_sbdata, b_sbdv},
          {e_req, e_we, e_be_b, m_act, e_err, e_err ? 3'd4 : 3'd0, e_addr,
           sbaddress_i, sbdata_i, master_r_rdata_i, master_r_valid_i});
      if (e_err) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        if (sbaddress_write_valid_i && sbreadonaddr_i) begin m_act = 1'b1; m_wr = 1'b0; m_gnt = 1'b0; end
        if (sbdata_write_valid_i)                      begin m_act = 1'b1; m_wr = 1'b1; m_gnt = 1'b0; end
        if (sbdata_read_valid_i && sbreadondata_i)     begin m_act = 1'b1; m_wr = 1'b0; m_gnt = 1'b0; end
      end else if (!m_gnt) begin
        if (master_gnt_i) m_gnt = 1'b1;
      end else if (master_r_valid_i) begin
        m_act = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
